// File: rtl/wave_shape_monitor_if.sv
// Bus between a triangle-wave source and wave_shape_monitor.
//   en, clr, wave_in : sample enable, synchronous clear and sample (source -> monitor)
//   dir_up           : monitor is tracking a rising ramp
//   peak_stb/val     : peak event strobe and most recent peak value
//   trough_stb/val   : trough event strobe and most recent trough value
//   period/_vld      : most recent trough-to-trough period and its update strobe
//   step_err         : sticky flag for any step larger than +/-1
interface wave_shape_monitor_if #(
    parameter int W        = 5,
    parameter int PERIOD_W = 8
);
    logic                en;
    logic                clr;
    logic [W-1:0]        wave_in;
    logic                dir_up;
    logic                peak_stb;
    logic [W-1:0]        peak_val;
    logic                trough_stb;
    logic [W-1:0]        trough_val;
    logic [PERIOD_W-1:0] period;
    logic                period_vld;
    logic                step_err;

    modport master (
        output en, clr, wave_in,
        input  dir_up, peak_stb, peak_val, trough_stb, trough_val,
               period, period_vld, step_err
    );

    modport slave (
        input  en, clr, wave_in,
        output dir_up, peak_stb, peak_val, trough_stb, trough_val,
               period, period_vld, step_err
    );
endinterface

// File: rtl/wave_shape_monitor.sv
// Monitors a triangle wave: tracks ramp direction, reports peaks and troughs,
// measures trough-to-trough period and flags any step larger than +/-1.
//   clk, rst_n : clock, asynchronous active-low reset
//   mon        : wave_shape_monitor_if.slave (en, clr, wave_in in; status out)
// All outputs are registered; a sample taken at edge N shows its strobes after N.
module wave_shape_monitor #(
    parameter int W        = 5,
    parameter int PERIOD_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    wave_shape_monitor_if.slave   mon
);
    typedef enum logic [1:0] {IDLE, ACQ, UP, DOWN} state_t;

    localparam logic signed [W:0]      D_P1    = {{W{1'b0}}, 1'b1};
    localparam logic signed [W:0]      D_M1    = '1;
    localparam logic [PERIOD_W-1:0]    CNT_MAX = '1;
    localparam logic [PERIOD_W-1:0]    CNT_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

    state_t              state, state_nxt;
    logic [W-1:0]        prev;
    logic [PERIOD_W-1:0] cnt;
    logic                armed;
    logic                dir_up_q, peak_stb_q, trough_stb_q, period_vld_q, step_err_q;
    logic [W-1:0]        peak_val_q, trough_val_q;
    logic [PERIOD_W-1:0] period_q;

    logic signed [W:0]   delta;
    logic                d_p1, d_m1, d_z, d_big;
    logic                err_set, peak_ev, trough_ev, disarm;
    logic [PERIOD_W-1:0] cnt_inc;

    // Non-modular step: operands zero-extended so 31->0 is -31, not +1.
    assign delta = $signed({1'b0, mon.wave_in}) - $signed({1'b0, prev});
    assign d_p1  = (delta == D_P1);
    assign d_m1  = (delta == D_M1);
    assign d_z   = (delta == '0);
    assign d_big = !(d_p1 || d_m1 || d_z);

    // Saturating increment; also equals min(cnt+1, max) for the period value.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    always_comb begin
        state_nxt = state;
        err_set   = 1'b0;
        peak_ev   = 1'b0;
        trough_ev = 1'b0;
        disarm    = 1'b0;
        case (state)
            IDLE: state_nxt = ACQ;
            ACQ: begin
                if (d_p1)       state_nxt = UP;
                else if (d_m1)  state_nxt = DOWN;
                else if (d_big) err_set   = 1'b1;
            end
            UP: begin
                if (d_big) begin
                    err_set   = 1'b1;
                    disarm    = 1'b1;
                    state_nxt = ACQ;
                end else if (d_m1) begin
                    peak_ev   = 1'b1;
                    state_nxt = DOWN;
                end
            end
            DOWN: begin
                if (d_big) begin
                    err_set   = 1'b1;
                    disarm    = 1'b1;
                    state_nxt = ACQ;
                end else if (d_p1) begin
                    trough_ev = 1'b1;
                    state_nxt = UP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            prev         <= '0;
            cnt          <= '0;
            armed        <= 1'b0;
            dir_up_q     <= 1'b0;
            peak_stb_q   <= 1'b0;
            trough_stb_q <= 1'b0;
            period_vld_q <= 1'b0;
            step_err_q   <= 1'b0;
            peak_val_q   <= '0;
            trough_val_q <= '0;
            period_q     <= '0;
        end else if (mon.clr) begin
            state        <= IDLE;
            prev         <= '0;
            cnt          <= '0;
            armed        <= 1'b0;
            dir_up_q     <= 1'b0;
            peak_stb_q   <= 1'b0;
            trough_stb_q <= 1'b0;
            period_vld_q <= 1'b0;
            step_err_q   <= 1'b0;
            peak_val_q   <= '0;
            trough_val_q <= '0;
            period_q     <= '0;
        end else begin
            peak_stb_q   <= 1'b0;
            trough_stb_q <= 1'b0;
            period_vld_q <= 1'b0;
            if (mon.en) begin
                prev     <= mon.wave_in;
                state    <= state_nxt;
                dir_up_q <= (state_nxt == UP);
                if (err_set) step_err_q <= 1'b1;
                if (peak_ev) begin
                    peak_stb_q <= 1'b1;
                    peak_val_q <= prev;
                end
                if (trough_ev) begin
                    trough_stb_q <= 1'b1;
                    trough_val_q <= prev;
                    cnt          <= '0;
                    armed        <= 1'b1;
                    // Only a trough preceded by another clean trough closes a period.
                    if (armed) begin
                        period_q     <= cnt_inc;
                        period_vld_q <= 1'b1;
                    end
                end else begin
                    cnt <= cnt_inc;
                end
                if (disarm) armed <= 1'b0;
            end
        end
    end

    assign mon.dir_up     = dir_up_q;
    assign mon.peak_stb   = peak_stb_q;
    assign mon.peak_val   = peak_val_q;
    assign mon.trough_stb = trough_stb_q;
    assign mon.trough_val = trough_val_q;
    assign mon.period     = period_q;
    assign mon.period_vld = period_vld_q;
    assign mon.step_err   = step_err_q;
endmodule

// File: tb/tb_wave_shape_monitor.sv
// Directed bench for wave_shape_monitor: two instances (PERIOD_W 8 and 4)
// driven by the same stimulus; expected values are hand-derived.
module tb_wave_shape_monitor;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clr;
    logic [4:0] wave;

    int n_chk  = 0;
    int n_pass = 0;

    wave_shape_monitor_if #(.W(5), .PERIOD_W(8)) aif ();
    wave_shape_monitor_if #(.W(5), .PERIOD_W(4)) bif ();

    assign aif.en = en;  assign aif.clr = clr;  assign aif.wave_in = wave;
    assign bif.en = en;  assign bif.clr = clr;  assign bif.wave_in = wave;

    wave_shape_monitor #(.W(5), .PERIOD_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .mon(aif));
    wave_shape_monitor #(.W(5), .PERIOD_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .mon(bif));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // One enabled sample, then check dut_a strobes after the edge.
    task automatic step(input int v, input bit ep, input bit et, input bit ev);
        wave = v[4:0]; en = 1'b1; clr = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("peak_stb@%0d", v),   aif.peak_stb,   ep);
        chk($sformatf("trough_stb@%0d", v), aif.trough_stb, et);
        chk($sformatf("period_vld@%0d", v), aif.period_vld, ev);
    endtask

    // Monotonic run a..b inclusive, no events expected.
    task automatic ramp(input int a, input int b);
        if (a <= b) for (int v = a; v <= b; v++) step(v, 0, 0, 0);
        else        for (int v = a; v >= b; v--) step(v, 0, 0, 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".dir_up"},     aif.dir_up,     0);
        chk({tag, ".peak_stb"},   aif.peak_stb,   0);
        chk({tag, ".peak_val"},   aif.peak_val,   0);
        chk({tag, ".trough_stb"}, aif.trough_stb, 0);
        chk({tag, ".trough_val"}, aif.trough_val, 0);
        chk({tag, ".period"},     aif.period,     0);
        chk({tag, ".period_vld"}, aif.period_vld, 0);
        chk({tag, ".step_err"},   aif.step_err,   0);
    endtask

    task automatic do_clr();
        clr = 1'b1; en = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; wave = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Ideal triangle: first trough arms, second yields period 64.
        step(0, 0, 0, 0);
        ramp(1, 31);
        chk("ramp.dir_up", aif.dir_up, 1);
        step(31, 0, 0, 0);
        step(30, 1, 0, 0);
        chk("peak_val", aif.peak_val, 31);
        chk("fall.dir_up", aif.dir_up, 0);
        ramp(29, 0);
        step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        chk("trough_val", aif.trough_val, 0);
        ramp(2, 31); step(31, 0, 0, 0); step(30, 1, 0, 0);
        ramp(29, 0); step(0, 0, 0, 0);
        step(1, 0, 1, 1);
        chk("ideal.period", aif.period, 64);
        chk("ideal.step_err", aif.step_err, 0);

        // Jump 12->15 while rising.
        ramp(2, 12);
        step(15, 0, 0, 0);
        chk("jump.step_err", aif.step_err, 1);
        chk("jump.dir_up", aif.dir_up, 0);
        step(16, 0, 0, 0);
        ramp(17, 31); step(31, 0, 0, 0); step(30, 1, 0, 0);
        ramp(29, 0); step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        ramp(2, 31); step(31, 0, 0, 0); step(30, 1, 0, 0);
        ramp(29, 0); step(0, 0, 0, 0);
        step(1, 0, 1, 1);
        chk("jump.period", aif.period, 64);
        chk("jump.sticky", aif.step_err, 1);

        do_clr();
        chk_zero("clr1");

        // Wrap 31->0, then clear with en high.
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("wrap.dir_up", aif.dir_up, 1);
        ramp(2, 31);
        step(0, 0, 0, 0);
        chk("wrap.step_err", aif.step_err, 1);
        do_clr();
        chk_zero("clr2");
        // From IDLE a large first step is not an error.
        step(5, 0, 0, 0);
        chk("idle.step_err", aif.step_err, 0);
        chk("idle.dir_up", aif.dir_up, 0);
        step(6, 0, 0, 0);
        chk("acq.dir_up", aif.dir_up, 1);

        // Enable gap with changing input after the first trough.
        ramp(7, 31); step(31, 0, 0, 0); step(30, 1, 0, 0);
        ramp(29, 0); step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        for (int i = 0; i < 10; i++) begin
            en = 1'b0; wave = 5'(7 + 2 * i);
            @(posedge clk); #1;
            chk($sformatf("gap%0d.strobes", i),
                {29'd0, aif.peak_stb, aif.trough_stb, aif.period_vld}, 0);
            chk($sformatf("gap%0d.dir_up", i), aif.dir_up, 1);
        end
        step(2, 0, 0, 0);
        chk("gap.step_err", aif.step_err, 0);
        ramp(3, 31); step(31, 0, 0, 0); step(30, 1, 0, 0);
        ramp(29, 0); step(0, 0, 0, 0);
        step(1, 0, 1, 1);
        chk("gap.period", aif.period, 64);

        // Slow triangle 0..20..0: 40 samples, saturates at 15 on the 4-bit counter.
        do_clr();
        step(0, 0, 0, 0);
        ramp(1, 20); step(19, 1, 0, 0);
        chk("slow.peak_val", aif.peak_val, 20);
        ramp(18, 0); step(1, 0, 1, 0);
        chk("slowb.vld1", bif.period_vld, 0);
        ramp(2, 20); step(19, 1, 0, 0);
        ramp(18, 0); step(1, 0, 1, 1);
        chk("slowa.period", aif.period, 40);
        chk("slowb.period", bif.period, 15);
        chk("slowb.vld2", bif.period_vld, 1);

        // Reset during a peak strobe on the falling ramp.
        ramp(2, 20);
        step(19, 1, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_zero("rst");
        chk("rstb.peak_stb", bif.peak_stb, 0);
        chk("rstb.period", bif.period, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(18, 0, 0, 0);
        step(17, 0, 0, 0);
        chk("rst.step_err", aif.step_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
